// File: rtl/fdd_sector_server.sv
// Disk-side sector responder: decodes read/write requests from the FDC, validates
// C/H/R against the image geometry and streams one 512-byte sector to/from image memory.
module fdd_sector_server #(
    parameter int unsigned TRACKS = 40,
    parameter int unsigned SIDES  = 1,
    parameter int unsigned SPT    = 9,
    parameter logic [23:0] BASE_A = 24'h000000,
    parameter logic [23:0] BASE_B = 24'h080000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disk_sr,
    output logic [31:0] disk_cr,
    input  logic [1:0]  img_present,
    input  logic [7:0]  img_first_id,
    input  logic [1:0]  disk_wp,
    output logic [7:0]  disk_data_in,
    output logic        disk_data_clkin,
    input  logic [7:0]  disk_data_out,
    output logic        disk_data_clkout,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_REQ,
        S_RD_PUSH,
        S_WR_PULL,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        drive_b_q;
    logic        write_q;
    logic        head_q;
    logic [6:0]  cyl_q;
    logic [7:0]  id_q;
    logic [8:0]  cnt_q;
    logic [23:0] addr_q;
    logic [7:0]  data_in_q;
    logic        clkin_q;
    logic        clkout_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [23:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        done_q;
    logic        nf_q;

    logic        req_any;
    logic [7:0]  rel_id;
    logic        nf_d;
    logic [23:0] addr_d;
    logic [31:0] sect;
    logic [31:0] off;
    logic        unused_bits;

    assign req_any = disk_sr[21] | disk_sr[20] | disk_sr[18] | disk_sr[17];
    assign rel_id  = id_q - img_first_id;

    always_comb begin
        nf_d = 1'b0;
        if (!(drive_b_q ? img_present[1] : img_present[0]))
            nf_d = 1'b1;
        if (32'(cyl_q) >= TRACKS)
            nf_d = 1'b1;
        if (head_q && (SIDES == 1))
            nf_d = 1'b1;
        if (id_q < img_first_id)
            nf_d = 1'b1;
        if (32'(rel_id) >= SPT)
            nf_d = 1'b1;
        if (write_q && (drive_b_q ? disk_wp[1] : disk_wp[0]))
            nf_d = 1'b1;
    end

    // Linear sector index within the image, scaled to bytes and wrapped to 24 bits.
    always_comb begin
        sect   = (32'(cyl_q) * SIDES + 32'(head_q)) * SPT + 32'(rel_id);
        off    = sect << 9;
        addr_d = (drive_b_q ? BASE_B : BASE_A) + off[23:0];
    end

    assign unused_bits = ^{disk_sr[31:22], disk_sr[19], off[31:24]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            drive_b_q   <= 1'b0;
            write_q     <= 1'b0;
            head_q      <= 1'b0;
            cyl_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_in_q   <= '0;
            clkin_q     <= 1'b0;
            clkout_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            nf_q        <= 1'b0;
        end else begin
            clkin_q  <= 1'b0;
            clkout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_any && !done_q) begin
                        state_q <= S_CHECK;
                        nf_q    <= 1'b0;
                        cnt_q   <= '0;
                        head_q  <= disk_sr[15];
                        cyl_q   <= disk_sr[14:8];
                        id_q    <= disk_sr[7:0];
                        if (disk_sr[21]) begin
                            drive_b_q <= 1'b1;
                            write_q   <= 1'b1;
                        end else if (disk_sr[20]) begin
                            drive_b_q <= 1'b0;
                            write_q   <= 1'b1;
                        end else if (disk_sr[18]) begin
                            drive_b_q <= 1'b1;
                            write_q   <= 1'b0;
                        end else begin
                            drive_b_q <= 1'b0;
                            write_q   <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    if (nf_d) begin
                        nf_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q <= addr_d;
                        if (write_q) begin
                            clkout_q <= 1'b1;
                            state_q  <= S_WR_PULL;
                        end else begin
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                // Request strobes rise one cycle after state entry and fall right after ack.
                S_RD_REQ: begin
                    if (!mem_rd_q) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= addr_q + {15'b0, cnt_q};
                    end else if (mem_ack) begin
                        mem_rd_q  <= 1'b0;
                        data_in_q <= mem_rdata;
                        clkin_q   <= 1'b1;
                        state_q   <= S_RD_PUSH;
                    end
                end
                S_RD_PUSH: begin
                    if (cnt_q == 9'h1FF) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 9'd1;
                        state_q <= S_RD_REQ;
                    end
                end
                S_WR_PULL: begin
                    mem_wdata_q <= disk_data_out;
                    state_q     <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (!mem_wr_q) begin
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= addr_q + {15'b0, cnt_q};
                    end else if (mem_ack) begin
                        mem_wr_q <= 1'b0;
                        if (cnt_q == 9'h1FF) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q    <= cnt_q + 9'd1;
                            clkout_q <= 1'b1;
                            state_q  <= S_WR_PULL;
                        end
                    end
                end
                S_DONE: begin
                    if (disk_sr[16] && !req_any) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign disk_cr          = {((|img_present) ? img_first_id : 8'h00), 19'b0, done_q, nf_q, 3'b0};
    assign disk_data_in     = data_in_q;
    assign disk_data_clkin  = clkin_q;
    assign disk_data_clkout = clkout_q;
    assign mem_addr         = mem_addr_q;
    assign mem_rd           = mem_rd_q;
    assign mem_wr           = mem_wr_q;
    assign mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_fdd_sector_server.sv
// Bench for fdd_sector_server: directed vector table, handshake/reset sequences and
// randomized commands checked against an arithmetic geometry model.
module tb_fdd_sector_server;

    localparam int TR  = 40;
    localparam int SD  = 1;
    localparam int SPTT = 9;

    localparam logic [4:0] RDA = 5'b00001;
    localparam logic [4:0] RDB = 5'b00010;
    localparam logic [4:0] WRA = 5'b01000;
    localparam logic [4:0] WRB = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] disk_sr = '0;
    logic [31:0] disk_cr;
    logic [1:0]  img_present = 2'b01;
    logic [7:0]  img_first_id = 8'hC1;
    logic [1:0]  disk_wp = 2'b00;
    logic [7:0]  disk_data_in;
    logic        disk_data_clkin;
    logic [7:0]  disk_data_out = '0;
    logic        disk_data_clkout;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;

    fdd_sector_server #(
        .TRACKS(40), .SIDES(1), .SPT(9), .BASE_A(24'h000000), .BASE_B(24'h080000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .disk_sr(disk_sr), .disk_cr(disk_cr),
        .img_present(img_present), .img_first_id(img_first_id), .disk_wp(disk_wp),
        .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
        .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    logic ack_force = 1'b0;
    int hi_cnt = 0;
    int fifo_idx = 0;
    logic fifo_pend = 1'b0;
    int pops = 0;
    int consec = 0;
    int busy_seen = 0;
    int last_ack_cyc = 0;
    logic prev_in = 1'b0, prev_out = 1'b0;
    logic [7:0]  push_q[$];
    int          push_cyc[$];
    logic [23:0] rdaddr_q[$];
    logic [23:0] wa_q[$];
    logic [7:0]  wd_q[$];

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    // Memory responder, write-FIFO model and strobe monitor share one process to avoid races.
    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            hi_cnt++;
            mem_ack = (hi_cnt == mem_lat) || ack_force;
        end else begin
            hi_cnt = 0;
            mem_ack = ack_force;
        end
        mem_rdata = mem_byte(mem_addr);
        if (fifo_pend) begin
            fifo_idx++;
            disk_data_out = fifo_idx[7:0];
        end
        fifo_pend = disk_data_clkout;
        if (disk_data_clkin) begin
            push_q.push_back(disk_data_in);
            push_cyc.push_back(cyc);
        end
        if (disk_data_clkout) pops++;
        if ((disk_data_clkin && prev_in) || (disk_data_clkout && prev_out)) consec++;
        prev_in  = disk_data_clkin;
        prev_out = disk_data_clkout;
        if (mem_rd || mem_wr) busy_seen++;
        if (mem_rd && mem_ack) rdaddr_q.push_back(mem_addr);
        if (mem_wr && mem_ack) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            last_ack_cyc = cyc;
        end
    end

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        push_q.delete(); push_cyc.delete(); rdaddr_q.delete();
        wa_q.delete(); wd_q.delete();
        pops = 0; fifo_idx = 0; disk_data_out = 8'h00; busy_seen = 0;
    endtask

    task automatic wait_done(input int limit, output bit seen, output int at);
        seen = 0;
        at = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (disk_cr[4]) begin
                seen = 1;
                at = cyc;
            end
        end
    endtask

    function automatic logic [31:0] sr_of(input logic [4:0] req, input logic head,
                                          input int cyl, input int id);
        logic [6:0] c;
        logic [7:0] r;
        c = 7'(cyl);
        r = 8'(id);
        return {10'b0, req, 1'b0, head, c, r};
    endfunction

    // Reference model: geometry rules evaluated with plain integer arithmetic.
    function automatic int sel_drive(input logic [4:0] req);
        if (req[4] || req[1]) return (req[4] || !req[3]) ? 1 : 0;
        return 0;
    endfunction

    function automatic bit sel_write(input logic [4:0] req);
        return req[4] || req[3];
    endfunction

    function automatic bit model_nf(input logic [4:0] req, input logic head, input int cyl,
                                    input int id, input logic [1:0] pres, input logic [1:0] wp,
                                    input int first);
        int drv;
        bit wr;
        drv = sel_drive(req);
        wr  = sel_write(req);
        return !pres[drv] || cyl >= TR || (head && SD == 1) || id < first ||
               (id - first) >= SPTT || (wr && wp[drv]);
    endfunction

    function automatic logic [23:0] model_addr(input logic [4:0] req, input logic head,
                                               input int cyl, input int id, input int first);
        int base;
        int idx;
        base = (sel_drive(req) == 1) ? 'h80000 : 0;
        idx  = (cyl * SD + int'(head)) * SPTT + (id - first);
        return 24'(base + idx * 512);
    endfunction

    task automatic run_cmd(input string nm, input logic [4:0] req, input logic head,
                           input int cyl, input int id, input logic [1:0] pres,
                           input logic [1:0] wp, input int first, input int lat,
                           input bit exp_nf, input logic [23:0] exp_addr);
        bit seen;
        int at, r, bad, sz;
        bit wr;
        wr = sel_write(req);
        @(negedge clk);
        img_present = pres;
        disk_wp = wp;
        img_first_id = 8'(first);
        mem_lat = lat;
        clear_mon();
        r = cyc;
        disk_sr = sr_of(req, head, cyl, id);
        wait_done(6000, seen, at);
        check({nm, ".done"}, seen, 1);
        check({nm, ".nf"}, disk_cr[3], exp_nf);
        check({nm, ".id"}, disk_cr[31:24], (pres != 0) ? first : 0);
        if (exp_nf) begin
            check({nm, ".nf_lat"}, at - r, 2);
            check({nm, ".strobes"}, push_q.size() + pops, 0);
        end else if (!wr) begin
            sz = push_q.size();
            check({nm, ".pushes"}, sz, 512);
            check({nm, ".pops"}, pops, 0);
            bad = 0;
            for (int i = 0; i < sz; i++) begin
                if (push_q[i] != mem_byte(exp_addr + 24'(i))) bad++;
                if (i >= rdaddr_q.size() || rdaddr_q[i] != exp_addr + 24'(i)) bad++;
                if (i > 0 && push_cyc[i] - push_cyc[i-1] != lat + 2) bad++;
            end
            check({nm, ".rd_stream"}, bad, 0);
            if (sz > 0) begin
                check({nm, ".first_push"}, push_cyc[0] - r, lat + 3);
                check({nm, ".done_time"}, at, push_cyc[sz-1] + 1);
            end
        end else begin
            check({nm, ".pops"}, pops, 512);
            check({nm, ".pushes"}, push_q.size(), 0);
            sz = wa_q.size();
            check({nm, ".writes"}, sz, 512);
            bad = 0;
            for (int i = 0; i < sz; i++) begin
                if (wa_q[i] != exp_addr + 24'(i)) bad++;
                if (wd_q[i] != 8'(i)) bad++;
            end
            check({nm, ".wr_stream"}, bad, 0);
            check({nm, ".done_time"}, at, last_ack_cyc + 1);
        end
        disk_sr = 32'h0001_0000;
        @(negedge clk);
        check({nm, ".exit"}, disk_cr[4], 0);
        disk_sr = '0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  req;
        logic        head;
        int          cyl;
        int          id;
        logic [1:0]  pres;
        logic [1:0]  wp;
        int          lat;
        bit          exp_nf;
        logic [23:0] exp_addr;
    } vec_t;

    function automatic vec_t mkv(input logic [4:0] req, input logic head, input int cyl,
                                 input int id, input logic [1:0] pres, input logic [1:0] wp,
                                 input int lat, input bit nf, input logic [23:0] a);
        vec_t v;
        v.req = req; v.head = head; v.cyl = cyl; v.id = id; v.pres = pres;
        v.wp = wp; v.lat = lat; v.exp_nf = nf; v.exp_addr = a;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        bit seen;
        int at, n0, bad;
        logic [4:0] rq;
        logic hd;
        int cy, first, id, lat;
        logic [1:0] pr, wp;

        tbl[0]  = mkv(RDA, 0, 2,  'hC3, 2'b01, 2'b00, 1, 0, 24'h002800);
        tbl[1]  = mkv(RDA, 0, 2,  'hCA, 2'b01, 2'b00, 1, 1, 24'h0);
        tbl[2]  = mkv(RDA, 0, 40, 'hC1, 2'b01, 2'b00, 1, 1, 24'h0);
        tbl[3]  = mkv(RDA, 1, 0,  'hC1, 2'b01, 2'b00, 1, 1, 24'h0);
        tbl[4]  = mkv(RDB, 0, 0,  'hC1, 2'b01, 2'b00, 1, 1, 24'h0);
        tbl[5]  = mkv(WRB, 0, 0,  'hC1, 2'b11, 2'b00, 1, 0, 24'h080000);
        tbl[6]  = mkv(WRB, 0, 0,  'hC1, 2'b11, 2'b10, 1, 1, 24'h0);
        tbl[7]  = mkv(RDA, 0, 0,  'hC0, 2'b01, 2'b00, 1, 1, 24'h0);
        tbl[8]  = mkv(RDA, 0, 39, 'hC9, 2'b01, 2'b00, 2, 0, 24'h02CE00);
        tbl[9]  = mkv(WRA | RDB, 0, 0, 'hC1, 2'b11, 2'b10, 1, 0, 24'h000000);
        tbl[10] = mkv(RDB, 0, 1,  'hC2, 2'b10, 2'b00, 3, 0, 24'h081400);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cr", disk_cr, {8'hC1, 24'h0});
        check("rst_outs", {disk_data_in, disk_data_clkin, disk_data_clkout, mem_addr,
                           mem_rd, mem_wr, mem_wdata}, 0);
        img_present = 2'b00;
        #1 check("rst_id_absent", disk_cr[31:24], 0);
        img_present = 2'b10;
        #1 check("rst_id_b", disk_cr[31:24], 8'hC1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Slow memory, then reset in the middle of the sector
        img_present = 2'b01;
        mem_lat = 5;
        clear_mon();
        disk_sr = sr_of(RDA, 0, 0, 'hC1);
        for (int n = 0; n < 1000 && push_q.size() < 20; n++) @(negedge clk);
        check("slow_progress", push_q.size() >= 20, 1);
        bad = 0;
        for (int i = 1; i < push_cyc.size(); i++)
            if (push_cyc[i] - push_cyc[i-1] != 7) bad++;
        check("slow_spacing", bad, 0);
        for (int n = 0; n < 20 && !mem_rd; n++) @(negedge clk);
        check("slow_mem_rd", mem_rd, 1);
        rst_n = 1'b0;
        disk_sr = '0;
        @(negedge clk);
        check("midrst_outs", {disk_cr[23:0], disk_data_in, disk_data_clkin, disk_data_clkout,
                              mem_addr, mem_rd, mem_wr, mem_wdata}, 0);
        rst_n = 1'b1;
        n0 = push_q.size();
        busy_seen = 0;
        @(posedge clk);
        #1 ack_force = 1'b1;
        @(posedge clk);
        #1 ack_force = 1'b0;
        repeat (10) @(negedge clk);
        check("late_ack_push", push_q.size() - n0, 0);
        check("late_ack_busy", busy_seen, 0);
        check("late_ack_done", disk_cr[4:3], 0);

        // Handshake: done holds while requests are up; fresh accept clears not-found
        mem_lat = 1;
        disk_sr = sr_of(RDA, 0, 2, 'hCA);
        wait_done(20, seen, at);
        check("hs_nf_done", seen, 1);
        check("hs_nf", disk_cr[3], 1);
        disk_sr = disk_sr | 32'h0001_0000;
        repeat (3) @(negedge clk);
        check("hs_hold", disk_cr[4], 1);
        disk_sr = 32'h0001_0000;
        @(negedge clk);
        check("hs_exit", disk_cr[4], 0);
        clear_mon();
        disk_sr = sr_of(RDA, 0, 0, 'hC1);
        @(negedge clk);
        check("hs_cr3_clear", disk_cr[3], 0);
        wait_done(3000, seen, at);
        check("hs_rd_done", seen, 1);
        check("hs_rd_pushes", push_q.size(), 512);
        disk_sr = 32'h0001_0000;
        @(negedge clk);
        disk_sr = '0;
        @(negedge clk);

        // Directed vectors
        for (int unsigned k = 0; k < 11; k++)
            run_cmd($sformatf("vec%0d", k), tbl[k].req, tbl[k].head, tbl[k].cyl, tbl[k].id,
                    tbl[k].pres, tbl[k].wp, 'hC1, tbl[k].lat, tbl[k].exp_nf, tbl[k].exp_addr);

        // Randomized commands against the geometry model
        for (int unsigned k = 0; k < 10; k++) begin
            rq = 5'($urandom_range(1, 31)) & 5'b11011;
            if (rq == 0) rq = RDA;
            hd = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: cy = 0;
                1: cy = 39;
                2: cy = 40;
                default: cy = $urandom_range(0, 41);
            endcase
            first = $urandom_range(1, 245);
            id = first + $urandom_range(0, 10) - 1;
            pr = 2'($urandom_range(1, 3));
            wp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            lat = $urandom_range(1, 3);
            run_cmd($sformatf("rnd%0d", k), rq, hd, cy, id, pr, wp, first, lat,
                    model_nf(rq, hd, cy, id, pr, wp, first),
                    model_addr(rq, hd, cy, id, first));
        end

        check("no_back_to_back_strobes", consec, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
